// File: rtl/writeback_forward_pipe.sv
// ---------------------------------------------------------------------------
// writeback_forward_pipe
//
// Producer side of operand forwarding. Holds the EX/MEM and MEM/WB pipeline
// registers of the writeback path and presents, for both stages, the
// regWrite/rdAddress pair used by the forwarding detection unit together with
// the matching forward data. MEM/WB also drives the register-file write port
// and a wrapping count of committed register writes.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   memStall            data memory not ready: both stages hold
//   flush_Ex            turn the instruction leaving EX into a bubble
//   valid_Ex, regWrite_Ex, memToReg_Ex, memRead_Ex, rdAddress_Ex,
//   aluResult_Ex        EX-stage instruction fields
//   memReadData         data memory read data for the EX/MEM instruction
//   regWrite_ExMem, memRead_ExMem, rdAddress_ExMem, forwardData_ExMem
//                       EX/MEM view (controls qualified with valid)
//   regWrite_MemWb, rdAddress_MemWb, writeData_MemWb
//                       MEM/WB view (controls qualified with valid)
//   rfWriteEnable, rfWriteAddress, rfWriteData
//                       register-file write port
//   retireCount         committed register writes, wraps
// ---------------------------------------------------------------------------
module writeback_forward_pipe #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   memStall,
  input  logic                   flush_Ex,
  input  logic                   valid_Ex,
  input  logic                   regWrite_Ex,
  input  logic                   memToReg_Ex,
  input  logic                   memRead_Ex,
  input  logic [4:0]             rdAddress_Ex,
  input  logic [DATA_WIDTH-1:0]  aluResult_Ex,
  input  logic [DATA_WIDTH-1:0]  memReadData,
  output logic                   regWrite_ExMem,
  output logic                   memRead_ExMem,
  output logic [4:0]             rdAddress_ExMem,
  output logic [DATA_WIDTH-1:0]  forwardData_ExMem,
  output logic                   regWrite_MemWb,
  output logic [4:0]             rdAddress_MemWb,
  output logic [DATA_WIDTH-1:0]  writeData_MemWb,
  output logic                   rfWriteEnable,
  output logic [4:0]             rfWriteAddress,
  output logic [DATA_WIDTH-1:0]  rfWriteData,
  output logic [COUNT_WIDTH-1:0] retireCount
);

  // EX/MEM stage
  logic                   ex_mem_valid_reg;
  logic                   ex_mem_reg_write_reg;
  logic                   ex_mem_mem_to_reg_reg;
  logic                   ex_mem_mem_read_reg;
  logic [4:0]             ex_mem_rd_reg;
  logic [DATA_WIDTH-1:0]  ex_mem_data_reg;

  // MEM/WB stage
  logic                   mem_wb_valid_reg;
  logic                   mem_wb_reg_write_reg;
  logic [4:0]             mem_wb_rd_reg;
  logic [DATA_WIDTH-1:0]  mem_wb_data_reg;

  logic [COUNT_WIDTH-1:0] retire_count_reg;
  logic                   rf_write_enable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_mem_valid_reg      <= 1'b0;
      ex_mem_reg_write_reg  <= 1'b0;
      ex_mem_mem_to_reg_reg <= 1'b0;
      ex_mem_mem_read_reg   <= 1'b0;
      ex_mem_rd_reg         <= '0;
      ex_mem_data_reg       <= '0;
      mem_wb_valid_reg      <= 1'b0;
      mem_wb_reg_write_reg  <= 1'b0;
      mem_wb_rd_reg         <= '0;
      mem_wb_data_reg       <= '0;
    end else if (!memStall) begin
      // A stall freezes both stages, so a flush raised during a stall only
      // takes effect on the first non-stalled edge.
      if (flush_Ex) begin
        ex_mem_valid_reg      <= 1'b0;
        ex_mem_reg_write_reg  <= 1'b0;
        ex_mem_mem_to_reg_reg <= 1'b0;
        ex_mem_mem_read_reg   <= 1'b0;
        ex_mem_rd_reg         <= '0;
        ex_mem_data_reg       <= '0;
      end else begin
        ex_mem_valid_reg      <= valid_Ex;
        ex_mem_reg_write_reg  <= regWrite_Ex;
        ex_mem_mem_to_reg_reg <= memToReg_Ex;
        ex_mem_mem_read_reg   <= memRead_Ex;
        ex_mem_rd_reg         <= rdAddress_Ex;
        ex_mem_data_reg       <= aluResult_Ex;
      end
      mem_wb_valid_reg     <= ex_mem_valid_reg;
      mem_wb_reg_write_reg <= ex_mem_reg_write_reg;
      mem_wb_rd_reg        <= ex_mem_rd_reg;
      // Loads take the memory data; everything else the ALU result.
      mem_wb_data_reg      <= ex_mem_mem_to_reg_reg ? memReadData : ex_mem_data_reg;
    end
  end

  // Suppressing the write while stalled means an instruction parked in
  // MEM/WB commits exactly once: on the edge that finally moves it on.
  assign rf_write_enable = mem_wb_valid_reg & mem_wb_reg_write_reg &
                           (mem_wb_rd_reg != 5'd0) & ~memStall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_count_reg <= '0;
    end else if (rf_write_enable) begin
      retire_count_reg <= retire_count_reg + 1'b1;
    end
  end

  assign regWrite_ExMem    = ex_mem_valid_reg & ex_mem_reg_write_reg;
  assign memRead_ExMem     = ex_mem_valid_reg & ex_mem_mem_read_reg;
  assign rdAddress_ExMem   = ex_mem_rd_reg;
  assign forwardData_ExMem = ex_mem_data_reg;

  assign regWrite_MemWb    = mem_wb_valid_reg & mem_wb_reg_write_reg;
  assign rdAddress_MemWb   = mem_wb_rd_reg;
  assign writeData_MemWb   = mem_wb_data_reg;

  assign rfWriteEnable     = rf_write_enable;
  assign rfWriteAddress    = mem_wb_rd_reg;
  assign rfWriteData       = mem_wb_data_reg;
  assign retireCount       = retire_count_reg;

endmodule

// File: tb/tb_writeback_forward_pipe.sv
module tb_writeback_forward_pipe;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          memStall, flush_Ex, valid_Ex, regWrite_Ex, memToReg_Ex, memRead_Ex;
  logic [4:0]    rdAddress_Ex;
  logic [DW-1:0] aluResult_Ex, memReadData;
  logic          regWrite_ExMem, memRead_ExMem;
  logic [4:0]    rdAddress_ExMem;
  logic [DW-1:0] forwardData_ExMem;
  logic          regWrite_MemWb;
  logic [4:0]    rdAddress_MemWb;
  logic [DW-1:0] writeData_MemWb;
  logic          rfWriteEnable;
  logic [4:0]    rfWriteAddress;
  logic [DW-1:0] rfWriteData;
  logic [CW-1:0] retireCount;

  int checks   = 0;
  int failures = 0;

  writeback_forward_pipe #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .memStall(memStall), .flush_Ex(flush_Ex),
    .valid_Ex(valid_Ex), .regWrite_Ex(regWrite_Ex), .memToReg_Ex(memToReg_Ex),
    .memRead_Ex(memRead_Ex), .rdAddress_Ex(rdAddress_Ex), .aluResult_Ex(aluResult_Ex),
    .memReadData(memReadData), .regWrite_ExMem(regWrite_ExMem),
    .memRead_ExMem(memRead_ExMem), .rdAddress_ExMem(rdAddress_ExMem),
    .forwardData_ExMem(forwardData_ExMem), .regWrite_MemWb(regWrite_MemWb),
    .rdAddress_MemWb(rdAddress_MemWb), .writeData_MemWb(writeData_MemWb),
    .rfWriteEnable(rfWriteEnable), .rfWriteAddress(rfWriteAddress),
    .rfWriteData(rfWriteData), .retireCount(retireCount)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_ex();
    flush_Ex = 0; valid_Ex = 0; regWrite_Ex = 0; memToReg_Ex = 0; memRead_Ex = 0;
    rdAddress_Ex = 0; aluResult_Ex = 0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [31:0] alu,
                       input logic m2r, input logic mrd);
    valid_Ex = 1; regWrite_Ex = 1; memToReg_Ex = m2r; memRead_Ex = mrd;
    rdAddress_Ex = rd; aluResult_Ex = alu;
  endtask

  task automatic chk_all_zero(input string tag);
    logic [31:0] agg;
    agg = {24'd0, regWrite_ExMem, memRead_ExMem, regWrite_MemWb, rfWriteEnable, retireCount}
        | {27'd0, rdAddress_ExMem} | {27'd0, rdAddress_MemWb} | {27'd0, rfWriteAddress}
        | forwardData_ExMem | writeData_MemWb | rfWriteData;
    chk(tag, agg, 32'd0);
  endtask

  initial begin
    reset = 1; memStall = 0; memReadData = 0;
    idle_ex();
    #12;
    chk_all_zero("reset_held_outputs");
    reset = 0;
    // 1. idle after reset
    repeat (4) tick();
    chk_all_zero("idle_outputs");
    chk("idle_retire", retireCount, 0);

    // 2. ALU op rd=5
    issue(5'd5, 32'h1234, 0, 0);
    tick();
    idle_ex();
    chk("alu_regwrite_exmem", regWrite_ExMem, 1);
    chk("alu_rd_exmem", rdAddress_ExMem, 5);
    chk("alu_fwd_exmem", forwardData_ExMem, 32'h1234);
    tick();
    chk("alu_rfwe", rfWriteEnable, 1);
    chk("alu_rfdata", rfWriteData, 32'h1234);
    chk("alu_rfaddr", rfWriteAddress, 5);
    chk("alu_regwrite_memwb", regWrite_MemWb, 1);
    tick();
    chk("alu_retire", retireCount, 1);
    chk("alu_rfwe_after", rfWriteEnable, 0);

    // 3. load rd=7
    issue(5'd7, 32'h100, 1, 1);
    tick();
    idle_ex();
    memReadData = 32'hCAFE;
    chk("load_memread_exmem", memRead_ExMem, 1);
    chk("load_fwd_exmem", forwardData_ExMem, 32'h100);
    tick();
    memReadData = 0;
    chk("load_memread_cleared", memRead_ExMem, 0);
    chk("load_wdata", writeData_MemWb, 32'hCAFE);
    chk("load_rfaddr", rfWriteAddress, 7);
    chk("load_rfwe", rfWriteEnable, 1);
    tick();
    chk("load_retire", retireCount, 2);

    // 4. stall with instruction in MEM/WB
    issue(5'd3, 32'hAAAA, 0, 0);
    tick();
    idle_ex();
    tick();
    chk("stall_pre_rfwe", rfWriteEnable, 1);
    memStall = 1;
    issue(5'd4, 32'hBBBB, 0, 0);
    #1;
    chk("stall_rfwe_comb", rfWriteEnable, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d_rfwe", i), rfWriteEnable, 0);
      chk($sformatf("stall%0d_rd_memwb", i), rdAddress_MemWb, 3);
      chk($sformatf("stall%0d_wdata", i), writeData_MemWb, 32'hAAAA);
      chk($sformatf("stall%0d_rd_exmem", i), rdAddress_ExMem, 0);
      chk($sformatf("stall%0d_retire", i), retireCount, 2);
    end
    idle_ex();
    memStall = 0;
    #1;
    chk("stall_release_rfwe", rfWriteEnable, 1);
    tick();
    chk("stall_retire", retireCount, 3);
    chk("stall_single_write", rfWriteEnable, 0);

    // 5. flush
    issue(5'd9, 32'h99, 0, 0);
    flush_Ex = 1;
    tick();
    idle_ex();
    chk("flush_regwrite_exmem", regWrite_ExMem, 0);
    chk("flush_rd_exmem", rdAddress_ExMem, 0);
    chk("flush_fwd_exmem", forwardData_ExMem, 0);
    tick();
    chk("flush_rfwe", rfWriteEnable, 0);
    tick();
    chk("flush_retire", retireCount, 3);
    // flush during stall
    issue(5'd10, 32'h10, 0, 0);
    tick();
    issue(5'd9, 32'h99, 0, 0);
    flush_Ex = 1;
    memStall = 1;
    tick();
    chk("flushstall_regwrite_exmem", regWrite_ExMem, 1);
    chk("flushstall_rd_exmem", rdAddress_ExMem, 10);
    chk("flushstall_fwd_exmem", forwardData_ExMem, 32'h10);
    memStall = 0;
    tick();
    idle_ex();
    chk("flushstall_bubble", regWrite_ExMem, 0);
    chk("flushstall_rfaddr", rfWriteAddress, 10);
    chk("flushstall_rfwe", rfWriteEnable, 1);
    tick();
    chk("flushstall_retire", retireCount, 4);

    // 6. rd=0
    issue(5'd0, 32'h55, 0, 0);
    tick();
    idle_ex();
    chk("rd0_regwrite_exmem", regWrite_ExMem, 1);
    tick();
    chk("rd0_regwrite_memwb", regWrite_MemWb, 1);
    chk("rd0_rfwe", rfWriteEnable, 0);
    tick();
    chk("rd0_retire", retireCount, 4);

    // memRead without memToReg: reported, but ALU data written back
    issue(5'd2, 32'h77, 0, 1);
    memReadData = 32'hDEAD;
    tick();
    idle_ex();
    chk("mrd_only_memread", memRead_ExMem, 1);
    tick();
    chk("mrd_only_wdata", writeData_MemWb, 32'h77);
    memReadData = 0;
    tick();
    chk("mrd_only_retire", retireCount, 5);

    // counter wrap: back-to-back writes up to all-ones, then one more
    for (int i = 0; i < 10; i++) begin
      issue(5'd1, i, 0, 0);
      tick();
    end
    idle_ex();
    repeat (3) tick();
    chk("wrap_all_ones", retireCount, 15);
    issue(5'd1, 32'h1, 0, 0);
    tick();
    idle_ex();
    repeat (2) tick();
    chk("wrap_zero", retireCount, 0);

    // asynchronous reset mid-operation
    issue(5'd6, 32'h66, 0, 0);
    tick();
    chk("midreset_pre", regWrite_ExMem, 1);
    idle_ex();
    #2 reset = 1;
    #1;
    chk_all_zero("midreset_outputs");
    reset = 0;
    tick();
    chk("midreset_rfwe", rfWriteEnable, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
